// File: rtl/dac_write_sequencer.sv
// Sequences 16-bit oscillator-trim DAC updates into two-byte SPI transactions (MSB first).
// Optional slew limiting is enabled by defining DAC_SLEW_LIMIT_EN.
module dac_write_sequencer #(
    parameter logic [15:0] DAC_RESET   = 16'h9E23,
    parameter logic [15:0] DAC_MIN     = 16'h0000,
    parameter logic [15:0] DAC_MAX     = 16'hFFFF,
    parameter logic [15:0] MAX_STEP    = 16'd512,
    parameter logic [15:0] TIMEOUT_CYC = 16'd2000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Update,
    input  logic [15:0] i_DAC_Val,
    input  logic        i_TX_Ready,
    output logic [7:0]  o_TX_Byte,
    output logic        o_TX_DV,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Err,
    output logic        o_Overrun,
    output logic [15:0] o_DAC_Active
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND_MSB,
        WAIT_MSB,
        SEND_LSB,
        WAIT_LSB,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] word_q, word_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;
    logic [15:0] active_q, active_d;

    logic        tmo_hit;
    logic        abort;
    logic [15:0] load_word;

    // Wide signed arithmetic so active +/- step can never wrap around 16 bits.
    function automatic logic [15:0] clamp_range(input logic signed [17:0] v);
        if (v < $signed({2'b00, DAC_MIN}))
            return DAC_MIN;
        else if (v > $signed({2'b00, DAC_MAX}))
            return DAC_MAX;
        else
            return v[15:0];
    endfunction

    assign tmo_hit = (tmo_q >= (TIMEOUT_CYC - 16'd1));

`ifdef DAC_SLEW_LIMIT_EN
    logic signed [17:0] req_s, act_s, step_s, diff_s;

    assign req_s  = $signed({2'b00, clamp_range($signed({2'b00, target_q}))});
    assign act_s  = $signed({2'b00, active_q});
    assign step_s = $signed({2'b00, MAX_STEP});
    assign diff_s = req_s - act_s;

    always_comb begin
        if (diff_s > step_s)
            load_word = clamp_range(act_s + step_s);
        else if (diff_s < -step_s)
            load_word = clamp_range(act_s - step_s);
        else
            load_word = req_s[15:0];
    end
`else
    assign load_word = clamp_range($signed({2'b00, target_q}));
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        word_d   = word_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        tmo_d    = tmo_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        active_d = active_q;
        abort    = 1'b0;

        // While busy, requests land in the one-entry buffer; DONE consumes it in the same cycle.
        if (i_Update && (state_q != IDLE)) begin
            pend_d   = i_DAC_Val;
            pend_v_d = 1'b1;
            if (pend_v_q && (state_q != DONE))
                ovr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (i_Update) begin
                    target_d = i_DAC_Val;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                word_d  = load_word;
                tmo_d   = '0;
                state_d = SEND_MSB;
            end
            SEND_MSB: begin
                tmo_d = tmo_q + 16'd1;
                if (i_TX_Ready) begin
                    byte_d  = word_q[15:8];
                    dv_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_MSB;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            WAIT_MSB: begin
                tmo_d = tmo_q + 16'd1;
                if (i_TX_Ready) begin
                    tmo_d   = '0;
                    state_d = SEND_LSB;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            SEND_LSB: begin
                tmo_d = tmo_q + 16'd1;
                if (i_TX_Ready) begin
                    byte_d  = word_q[7:0];
                    dv_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT_LSB;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            WAIT_LSB: begin
                tmo_d = tmo_q + 16'd1;
                if (i_TX_Ready) begin
                    tmo_d   = '0;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            DONE: begin
                active_d = word_q;
                done_d   = 1'b1;
                if (pend_v_q) begin
                    target_d = pend_q;
                    pend_v_d = i_Update;
                    state_d  = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            err_d    = 1'b1;
            pend_v_d = 1'b0;
            tmo_d    = '0;
            state_d  = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= IDLE;
            target_q <= '0;
            word_q   <= DAC_RESET;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            tmo_q    <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            active_q <= DAC_RESET;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            word_q   <= word_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            active_q <= active_d;
        end
    end

    assign o_TX_Byte    = byte_q;
    assign o_TX_DV      = dv_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_Err        = err_q;
    assign o_Overrun    = ovr_q;
    assign o_DAC_Active = active_q;

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed bench for dac_write_sequencer; range is narrowed to 0100..F000 to exercise clamping.
// Expectations follow DAC_SLEW_LIMIT_EN when it is defined.
module tb_dac_write_sequencer;

    logic        clk;
    logic        rstN;
    logic        update;
    logic [15:0] dacVal;
    logic        txReady;
    logic [7:0]  txByte;
    logic        txDv;
    logic        busy;
    logic        done;
    logic        err;
    logic        overrun;
    logic [15:0] dacActive;

    int checks = 0;
    int errors = 0;

    dac_write_sequencer #(
        .DAC_RESET  (16'h9E23),
        .DAC_MIN    (16'h0100),
        .DAC_MAX    (16'hF000),
        .MAX_STEP   (16'd512),
        .TIMEOUT_CYC(16'd2000)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rstN),
        .i_Update    (update),
        .i_DAC_Val   (dacVal),
        .i_TX_Ready  (txReady),
        .o_TX_Byte   (txByte),
        .o_TX_DV     (txDv),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Err       (err),
        .o_Overrun   (overrun),
        .o_DAC_Active(dacActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One-cycle update pulse; returns just after the edge that samples it (cycle 0).
    task automatic applyStimulus(input logic [15:0] val);
        update = 1'b1;
        dacVal = val;
        tick();
        update = 1'b0;
    endtask

    task automatic resetDut();
        rstN   = 1'b0;
        update = 1'b0;
        dacVal = '0;
        tick();
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // Full write with ready held high, checking the cycle-exact byte/done schedule.
    task automatic doWrite(input logic [15:0] val, input logic [15:0] expWord);
        applyStimulus(val);
        checkOutput("busyAfterUpdate", {15'd0, busy}, 16'd1);
        tick();
        checkOutput("dvLoad", {15'd0, txDv}, 16'd0);
        tick();
        checkOutput("dvMsb", {15'd0, txDv}, 16'd1);
        checkOutput("byteMsb", {8'd0, txByte}, {8'd0, expWord[15:8]});
        tick();
        checkOutput("dvWaitMsb", {15'd0, txDv}, 16'd0);
        checkOutput("byteHeld", {8'd0, txByte}, {8'd0, expWord[15:8]});
        tick();
        checkOutput("dvLsb", {15'd0, txDv}, 16'd1);
        checkOutput("byteLsb", {8'd0, txByte}, {8'd0, expWord[7:0]});
        tick();
        checkOutput("doneEarly", {15'd0, done}, 16'd0);
        tick();
        checkOutput("done", {15'd0, done}, 16'd1);
        checkOutput("active", dacActive, expWord);
        tick();
        checkOutput("doneOnePulse", {15'd0, done}, 16'd0);
        checkOutput("busyIdle", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int n;
        int dvCount;

        txReady = 1'b1;
        resetDut();
        checkOutput("rstBusy", {15'd0, busy}, 16'd0);
        checkOutput("rstDv", {15'd0, txDv}, 16'd0);
        checkOutput("rstByte", {8'd0, txByte}, 16'd0);
        checkOutput("rstDone", {15'd0, done}, 16'd0);
        checkOutput("rstErr", {15'd0, err}, 16'd0);
        checkOutput("rstOverrun", {15'd0, overrun}, 16'd0);
        checkOutput("rstActive", dacActive, 16'h9E23);

`ifdef DAC_SLEW_LIMIT_EN
        doWrite(16'hFFFF, 16'hA023);
        resetDut();
        doWrite(16'h0000, 16'h9C23);
        doWrite(16'h9E00, 16'h9E00);
`else
        doWrite(16'h1234, 16'h1234);
        doWrite(16'hFFFF, 16'hF000);
        doWrite(16'h0000, 16'h0100);
`endif

        // A starts, B becomes pending, C overwrites B: one overrun and C is written next.
        resetDut();
        applyStimulus(16'h9F00);
        tick();
        tick();
        checkOutput("ovrMsbA", {8'd0, txByte}, 16'h009F);
        update = 1'b1;
        dacVal = 16'h9D00;
        tick();
        checkOutput("ovrFirstPending", {15'd0, overrun}, 16'd0);
        dacVal = 16'h9E80;
        tick();
        update = 1'b0;
        checkOutput("ovrPulse", {15'd0, overrun}, 16'd1);
        checkOutput("ovrLsbA", {8'd0, txByte}, 16'h0000);
        tick();
        checkOutput("ovrPulseEnds", {15'd0, overrun}, 16'd0);
        tick();
        checkOutput("ovrDoneA", dacActive, 16'h9F00);
        tick();
        tick();
        checkOutput("ovrDvMsbC", {15'd0, txDv}, 16'd1);
        checkOutput("ovrMsbC", {8'd0, txByte}, 16'h009E);
        tick();
        tick();
        checkOutput("ovrLsbC", {8'd0, txByte}, 16'h0080);
        tick();
        tick();
        checkOutput("ovrDoneC", {15'd0, done}, 16'd1);
        checkOutput("ovrActiveC", dacActive, 16'h9E80);
        tick();
        checkOutput("ovrIdle", {15'd0, busy}, 16'd0);

        // Ready drops after the MSB strobe; abort arrives TIMEOUT_CYC cycles later.
        applyStimulus(16'h9E00);
        tick();
        tick();
        checkOutput("tmoMsb", {8'd0, txByte}, 16'h009E);
        txReady = 1'b0;
        n = 0;
        while (!err && n < 3000) begin
            tick();
            n++;
            if (txDv) begin
                checkOutput("tmoNoDv", {15'd0, txDv}, 16'd0);
            end
        end
        checkOutput("tmoCycles", n[15:0], 16'd2000);
        checkOutput("tmoIdle", {15'd0, busy}, 16'd0);
        checkOutput("tmoActive", dacActive, 16'h9E80);
        tick();
        checkOutput("tmoErrPulse", {15'd0, err}, 16'd0);
        txReady = 1'b1;
        doWrite(16'h9E40, 16'h9E40);

        // Reset between MSB and LSB aborts immediately with no LSB strobe.
        applyStimulus(16'h9F00);
        tick();
        tick();
        checkOutput("rstMidMsb", {15'd0, txDv}, 16'd1);
        rstN = 1'b0;
        #1;
        checkOutput("rstMidDv", {15'd0, txDv}, 16'd0);
        checkOutput("rstMidByte", {8'd0, txByte}, 16'd0);
        checkOutput("rstMidBusy", {15'd0, busy}, 16'd0);
        checkOutput("rstMidActive", dacActive, 16'h9E23);
        tick();
        rstN = 1'b1;
        dvCount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (txDv) dvCount++;
        end
        checkOutput("rstMidNoLsb", dvCount[15:0], 16'd0);
        checkOutput("rstMidActiveHold", dacActive, 16'h9E23);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
